// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed seven-segment driver fed by an MMIO write strobe.
// Hex words load directly; decimal words go through a sequential double-dabble.
module seg7_scan_display #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        dec_mode,
    output logic        busy,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        ERR
    } state_t;

    state_t      state;
    logic [4:0]  iter;
    logic [31:0] bcd;
    logic [26:0] shreg;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic        err_pat;

    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       idx;

    logic [31:0] bcd_adj;
    logic [31:0] bcd_next;
    logic [7:0]  blank_next;
    logic [3:0]  cur_digit;
    logic [7:0]  seg_next;
    logic        seen_nonzero;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    // One double-dabble step, plus leading-zero blanking of the resulting digits
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 8; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd[4*i +: 4];
        end
        bcd_next = {bcd_adj[30:0], shreg[26]};

        blank_next   = '0;
        seen_nonzero = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            if (bcd_next[4*i +: 4] != 4'd0)
                seen_nonzero = 1'b1;
            blank_next[i] = !seen_nonzero;
        end
    end

    always_comb begin
        cur_digit = digits[{idx, 2'b00} +: 4];
        if (blank[idx])
            seg_next = 8'h00;
        else if (err_pat)
            seg_next = 8'h40;
        else
            seg_next = {1'b0, decode(cur_digit)};
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            iter    <= '0;
            bcd     <= '0;
            shreg   <= '0;
            digits  <= '0;
            blank   <= 8'hFF;
            err_pat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        if (!dec_mode) begin
                            digits  <= wr_data;
                            blank   <= '0;
                            err_pat <= 1'b0;
                        end else if (wr_data > 32'd99_999_999) begin
                            state <= ERR;
                        end else begin
                            bcd   <= '0;
                            shreg <= wr_data[26:0];
                            iter  <= '0;
                            state <= CONV;
                        end
                    end
                end
                CONV: begin
                    bcd   <= bcd_next;
                    shreg <= shreg << 1;
                    // The final shift result goes straight to the store on the same edge
                    if (iter == 5'd26) begin
                        digits  <= bcd_next;
                        blank   <= blank_next;
                        err_pat <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        iter <= iter + 5'd1;
                    end
                end
                ERR: begin
                    err_pat <= 1'b1;
                    blank   <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= '0;
            seg      <= '0;
        end else begin
            if (scan_cnt == CNT_LAST) begin
                scan_cnt <= '0;
                idx      <= idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an  <= 8'h01 << idx;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: scan order, hex/decimal writes,
// error pattern, dropped writes and reset during a conversion.
module tb_seg7_scan_display;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        dec_mode = 1'b0;
    logic        busy;
    logic [7:0]  an;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .dec_mode(dec_mode),
        .busy(busy),
        .an(an),
        .seg(seg)
    );

    typedef struct {
        logic        dec;
        logic [31:0] data;
        int          exp_busy;
        logic [63:0] exp_frame;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic dec, input logic [31:0] data);
        wr_en    = 1'b1;
        dec_mode = dec;
        wr_data  = data;
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        dec_mode = 1'b0;
        wr_data  = '0;
    endtask

    // Counts busy cycles; while busy, every shown digit must match hold_frame
    task automatic measureBusy(input logic [63:0] hold_frame, output int cnt, output int hold_err);
        cnt = 0;
        hold_err = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            for (int d = 0; d < 8; d++)
                if (an[d] && seg !== hold_frame[8*d +: 8]) hold_err++;
        end
    endtask

    task automatic captureFrame(output logic [63:0] frame, output int bad_an);
        logic [7:0] seen;
        seen   = '0;
        frame  = '0;
        bad_an = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            if (!$onehot(an)) bad_an++;
            for (int d = 0; d < 8; d++)
                if (an[d]) begin
                    frame[8*d +: 8] = seg;
                    seen[d] = 1'b1;
                end
        end
        if (seen != 8'hFF) bad_an++;
    endtask

    initial begin
        int          rst_err;
        int          scan_err;
        int          seg_err;
        int          cnt;
        int          herr;
        int          bad;
        logic [63:0] frame;
        logic [63:0] prev_frame;
        logic [7:0]  exp_an;

        vecs[0] = '{1'b0, 32'h1234ABCF,   0,  64'h065B4F66777C3971};
        vecs[1] = '{1'b1, 32'd12345,      27, 64'h000000065B4F666D};
        vecs[2] = '{1'b1, 32'd0,          27, 64'h000000000000003F};
        vecs[3] = '{1'b1, 32'd99_999_999, 27, 64'h6F6F6F6F6F6F6F6F};
        vecs[4] = '{1'b1, 32'd100_000_000, 1, 64'h4040404040404040};
        vecs[5] = '{1'b0, 32'h00000000,   0,  64'h3F3F3F3F3F3F3F3F};
        vecs[6] = '{1'b1, 32'd10,         27, 64'h000000000000063F};

        // Reset held for three cycles, then the scan order from release
        rst_err = 0;
        repeat (3) begin
            @(negedge clk);
            if (an !== 8'h00 || seg !== 8'h00 || busy !== 1'b0) rst_err++;
        end
        checkOutput("reset_outputs", 64'(rst_err), 64'd0);
        rst = 1'b1;

        scan_err = 0;
        seg_err  = 0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            exp_an = 8'h01 << ((k / SCAN_DIV) % 8);
            if (an !== exp_an) scan_err++;
            if (seg !== 8'h00) seg_err++;
        end
        checkOutput("scan_sequence", 64'(scan_err), 64'd0);
        checkOutput("scan_blank_seg", 64'(seg_err), 64'd0);

        prev_frame = '0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].dec, vecs[i].data);
            measureBusy(prev_frame, cnt, herr);
            checkOutput($sformatf("busy_cycles_%0d", i), 64'(cnt), 64'(vecs[i].exp_busy));
            if (vecs[i].exp_busy > 0)
                checkOutput($sformatf("hold_display_%0d", i), 64'(herr), 64'd0);
            captureFrame(frame, bad);
            checkOutput($sformatf("frame_%0d", i), frame, vecs[i].exp_frame);
            checkOutput($sformatf("an_onehot_%0d", i), 64'(bad), 64'd0);
            prev_frame = vecs[i].exp_frame;
        end

        // Hex write issued mid-conversion must be dropped
        applyStimulus(1'b1, 32'd7);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            if (k == 9) begin
                wr_en    = 1'b1;
                wr_data  = 32'hFFFFFFFF;
                dec_mode = 1'b0;
            end else begin
                wr_en    = 1'b0;
                wr_data  = '0;
            end
        end
        wr_en   = 1'b0;
        wr_data = '0;
        checkOutput("dropped_busy_cycles", 64'(cnt), 64'd27);
        captureFrame(frame, bad);
        checkOutput("dropped_frame", frame, 64'h0000000000000007);

        // Reset during a conversion aborts it and blanks the store
        applyStimulus(1'b1, 32'd12345);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_an", 64'(an), 64'd0);
        checkOutput("midreset_seg", 64'(seg), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        measureBusy(64'd0, cnt, herr);
        checkOutput("midreset_no_busy", 64'(cnt), 64'd0);
        captureFrame(frame, bad);
        checkOutput("midreset_frame", frame, 64'd0);
        checkOutput("midreset_an_onehot", 64'(bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
